// File: rtl/axis_mono_framer.sv
// Stereo I2S word pairs to mono samples: averages L/R, buffers them in a FIFO and
// frames the output stream with TLAST every FRAME_LEN samples.
module axis_mono_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  S_AXIS_TLAST,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic [15:0]           drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FRAME_LEN);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

  typedef enum logic {WAIT_L, WAIT_R} state_t;

  state_t                state, state_nxt;
  logic                  in_en;
  logic [23:0]           l_reg;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  fifo_full, fifo_empty;
  logic [FW-1:0]         frame_cnt;
  logic                  push, l_load, drop_inc, m_hs;
  logic [24:0]           sum;
  logic [DATA_WIDTH-1:0] mono;
  logic                  unused_bits;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // 25-bit signed sum; dropping bit 0 is the arithmetic (floor) halving
  assign sum  = {l_reg[23], l_reg} + {S_AXIS_TDATA[31], S_AXIS_TDATA[31:8]};
  assign mono = {{(DATA_WIDTH-24){sum[24]}}, sum[24:1]};

  assign unused_bits = ^{S_AXIS_TDATA[7:0], sum[0]};

  assign m_hs          = M_AXIS_TVALID && M_AXIS_TREADY;
  assign M_AXIS_TVALID = !fifo_empty;
  assign M_AXIS_TDATA  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign M_AXIS_TLAST  = !fifo_empty && (frame_cnt == FRAME_LAST);

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) state <= WAIT_L;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    S_AXIS_TREADY = 1'b0;
    push          = 1'b0;
    l_load        = 1'b0;
    drop_inc      = 1'b0;
    case (state)
      WAIT_L: begin
        S_AXIS_TREADY = in_en;
        if (in_en && S_AXIS_TVALID) begin
          if (S_AXIS_TLAST) begin
            drop_inc = 1'b1;
          end else begin
            l_load    = 1'b1;
            state_nxt = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        // full is sampled before any same-cycle pop, so a pop never admits a push
        S_AXIS_TREADY = in_en && !fifo_full;
        if (S_AXIS_TREADY && S_AXIS_TVALID) begin
          if (S_AXIS_TLAST) begin
            push      = 1'b1;
            state_nxt = WAIT_L;
          end else begin
            l_load   = 1'b1;
            drop_inc = 1'b1;
          end
        end
      end
      default: state_nxt = WAIT_L;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      in_en      <= 1'b0;
      l_reg      <= '0;
      drop_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_cnt  <= '0;
    end else begin
      in_en <= 1'b1;
      if (l_load) l_reg <= S_AXIS_TDATA[31:8];
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + 16'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (m_hs) begin
        rd_ptr    <= rd_ptr + 1'b1;
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= mono;
  end

endmodule
